muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the integer M-extension slots of the ALU (aluctl encodings 6'b001000–6'b001111). It accepts one operation from the execute stage, runs a 32-step shift-add or restoring-divide loop, and holds the pipeline with a stall request until the result is ready. The execute stage selects `result` into its result mux when `valid` is high.

---
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-step shift-add multiply / restoring divide sequencer with pipeline stall request.
// Optional feature macro MULDIV_DIV_EN: when undefined, divide ops complete in one cycle with result 0.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            stall_req,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic        sgn1_s, sgn2_s;
  logic [31:0] mag1_s, mag2_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_step_s, div_step_s, step_s, prod_s;
  logic [31:0] div_mag_s, final_s;

  // Operand signedness and magnitudes; negation flag is the rem-vs-others sign rule
  always_comb begin
    sgn1_s = op1[31] & (op != 3'b011) & (op != 3'b101) & (op != 3'b111);
    sgn2_s = op2[31] & (op != 3'b010) & (op != 3'b011) & (op != 3'b101) & (op != 3'b111);
    mag1_s = sgn1_s ? (32'h0 - op1) : op1;
    mag2_s = sgn2_s ? (32'h0 - op2) : op2;
  end

`ifdef MULDIV_DIV_EN
  logic        div0_s, ovf_s;
  logic [32:0] div_shift_s, div_trial_s;

  // Divide-by-zero and signed overflow finish without iterating
  always_comb begin
    div0_s    = (op2 == 32'h0);
    ovf_s     = ~op[0] & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
    special_s = op[2] & (div0_s | ovf_s);
    if (div0_s) begin
      special_res_s = op[1] ? op1 : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // Restoring step: acc high half is the remainder, low half shifts dividend out and quotient in
  always_comb begin
    div_shift_s = {acc_q[63:32], acc_q[31]};
    div_trial_s = div_shift_s - {1'b0, opb_q};
    if (div_trial_s[32]) begin
      div_step_s = {div_shift_s[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_step_s = {div_trial_s[31:0], acc_q[30:0], 1'b1};
    end
  end
`else
  // No divide datapath: every divide op completes immediately with zero
  always_comb begin
    special_s     = op[2];
    special_res_s = 32'h0;
    div_step_s    = 64'h0;
  end
`endif

  // Shift-add step and final sign fix-up / result selection
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'h0);
    mul_step_s = {mul_sum_s, acc_q[31:1]};
    step_s     = op_q[2] ? div_step_s : mul_step_s;
    prod_s     = neg_q ? (64'h0 - step_s) : step_s;
    div_mag_s  = op_q[1] ? step_s[63:32] : step_s[31:0];
    if (op_q[2]) begin
      final_s = neg_q ? (32'h0 - div_mag_s) : div_mag_s;
    end else begin
      final_s = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  // Next-state and stall logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          stall_req = 1'b1;
          op_d      = op;
          cnt_d     = 5'd0;
          neg_d     = (op == 3'b110) ? sgn1_s : (sgn1_s ^ sgn2_s);
          opb_d     = mag2_s;
          acc_d     = {32'h0, mag1_s};
          if (special_s) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = special_res_s;
          end else begin
            state_d = S_BUSY;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = final_s;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      opb_q    <= 32'h0;
      acc_q    <= 64'h0;
      result_q <= 32'h0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle timeline model plus directed vectors with literal results.
module tb_muldiv_seq;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        kill;
  logic        stall_req;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op1      (op1),
    .op2      (op2),
    .kill     (kill),
    .stall_req(stall_req),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: expected result and cycles from acceptance edge to valid
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    lat = 32;
    r   = 32'h0;
    case (o)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      default: begin
        if (!DIV_EN) begin
          r = 32'h0; lat = 0;
        end else if (b == 32'h0) begin
          lat = 0; r = o[1] ? a : 32'hFFFF_FFFF;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 0; r = o[1] ? 32'h0 : 32'h8000_0000;
        end else begin
          case (o)
            3'b100:  p = sa / sb;
            3'b101:  p = ua / ub;
            3'b110:  p = sa % sb;
            default: p = ua % ub;
          endcase
          r = p[31:0];
        end
      end
    endcase
  endfunction

  // Timeline model: left<0 idle, left>0 cycles of iteration remaining, left==0 valid cycle
  int          left = -1;
  int          m_lat;
  logic [31:0] pend;
  logic [31:0] held = 32'h0;

  initial begin : scoreboard
    forever begin
      @(posedge clk);
      if (rst) begin
        left = -1;
        held = 32'h0;
      end else if (left < 0) begin
        if (start && !kill) begin
          model(op, op1, op2, pend, m_lat);
          left = m_lat;
          if (m_lat == 0) held = pend;
        end
      end else if (left == 0) begin
        left = -1;
      end else if (kill) begin
        left = -1;
      end else begin
        left--;
        if (left == 0) held = pend;
      end
      @(negedge clk);
      check("cyc valid", {31'h0, valid}, {31'h0, left == 0});
      check("cyc busy", {31'h0, busy}, {31'h0, left > 0});
      check("cyc stall_req", {31'h0, stall_req}, {31'h0, (left < 0 && start && !kill) || left > 0});
      check("cyc result", result, held);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_check(input logic [31:0] lit, input int lat_lit, input string nm);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " valid seen"}, {31'h0, valid}, 32'h1);
    check({nm, " latency"}, n, lat_lit);
    check({nm, " result"}, result, lit);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int lat_lit, input string nm);
    issue(o, a, b);
    wait_check(lit, lat_lit, nm);
  endtask

  initial begin : stimulus
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; op1 = 32'h0; op2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", {31'h0, valid}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset stall_req", {31'h0, stall_req}, 32'h0);
    rst = 1'b0;

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, "mul 7*-3");

    // Kill in BUSY cycle 10, then a start in the following idle cycle
    issue(3'b000, 32'h5, 32'h6);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill valid", {31'h0, valid}, 32'h0);
    check("kill busy", {31'h0, busy}, 32'h0);
    check("kill stall_req", {31'h0, stall_req}, 32'h0);
    check("kill result kept", result, 32'hFFFF_FFEB);
    start = 1'b1; op = 3'b000; op1 = 32'h3; op2 = 32'h4;
    #1 check("post-kill accept stall", {31'h0, stall_req}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_check(32'hC, 32, "mul after kill");

    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32, "mulh");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "mulhsu");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "mulh min*min");

    run_op(3'b100, 32'hFFFF_FFF9, 32'h2, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 32 : 0, "div -7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 32 : 0, "rem -7/2");
    run_op(3'b100, 32'h7, 32'hFFFF_FFFE, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 32 : 0, "div 7/-2");
    run_op(3'b110, 32'h7, 32'hFFFF_FFFE, DIV_EN ? 32'h1 : 32'h0, DIV_EN ? 32 : 0, "rem 7/-2");
    run_op(3'b101, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'h0, DIV_EN ? 32 : 0, "divu 100/7");
    run_op(3'b111, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'h0, DIV_EN ? 32 : 0, "remu 100/7");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, DIV_EN ? 32 : 0, "divu min/max");

    run_op(3'b101, 32'd5, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 0, "divu 5/0");
    run_op(3'b110, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'h0, 0, "rem 5/0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0, 0, "div ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem ovf");

    // start held through BUSY/DONE: ignored there, accepted in the next idle cycle
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; op1 = 32'h2; op2 = 32'h3;
    @(posedge clk); #1;
    op = 3'b011; op1 = 32'hFFFF_FFFF; op2 = 32'h2;
    wait_check(32'h6, 32, "b2b first");
    @(posedge clk); #1;
    check("b2b idle stall", {31'h0, stall_req}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_check(32'h1, 32, "b2b second");

    // Reset during a divide
    issue(3'b101, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst valid", {31'h0, valid}, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst result", result, 32'h0);
    check("rst stall_req", {31'h0, stall_req}, 32'h0);
    rst = 1'b0;

    run_op(3'b100, 32'd9, 32'd3, DIV_EN ? 32'd3 : 32'h0, DIV_EN ? 32 : 0, "div 9/3");

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
